// File: rtl/mem_defs.sv
// mem_defs: definitions shared by the memory arbiter, the cpu and MEM.
//   mem_cmd_e   : memory command encodings (MNONE/MREAD/MWRITE).
//   arb_state_e : arbiter FSM states (IDLE/ISSUE/WAIT/DONE).
//   cmd_for()   : maps a latched write-enable onto the command to issue.
package mem_defs;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } arb_state_e;

  function automatic mem_cmd_e cmd_for(input logic we);
    return we ? MWRITE : MREAD;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner selection for the two-port memory arbiter.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined     : on contention the port that was NOT granted last wins.
//   not defined : fixed priority, port 0 wins on contention.
// Ports:
//   req0, req1  in  : request levels of port 0 (cpu) and port 1 (loader)
//   last_grant  in  : port granted most recently (only used with round robin)
//   any_req     out : at least one port is requesting
//   winner      out : selected port (0 or 1); 0 when nobody requests
module arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic any_req,
  output logic winner
);

  assign any_req = req0 | req1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // A lone requester always wins; on contention the pointer decides.
  assign winner = (req0 && req1) ? ~last_grant : req1;
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  // Port 1 only wins when port 0 is idle.
  assign winner = ~req0 & req1;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer in front of the single
// synchronous-read data memory. One transaction at a time, 4 cycles each:
// IDLE (sample/grant) -> ISSUE (command on bus) -> WAIT (read data returns)
// -> DONE (ack pulse) -> IDLE.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin on contention,
// see arb_pick); without it port 0 has fixed priority.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN   : port N request level, write enable, address, data
//   ackN                    : one-cycle completion pulse for port N
//   rdataN                  : port N read data, valid with ackN and held
//   mem_cmd/mem_addr/mem_wdata : command bus to MEM (registered sources only)
//   mem_rdata               : MEM read data, valid the cycle after MREAD
//   busy                    : FSM not in IDLE
//   grant                   : owner of the current/last transaction
module mem_arbiter
  import mem_defs::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic any_req;
  logic winner;
  logic last_grant;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  assign last_grant = ptr_q;

  // Pointer follows every grant so the other port wins the next contention.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && any_req) begin
      ptr_d = winner;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign last_grant = 1'b0;
`endif

  arb_pick u_arb_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (winner)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          // Latch the winner's request so requesters may change afterwards
          // without disturbing the command bus.
          grant_d = winner;
          we_d    = winner ? we1    : we0;
          addr_d  = winner ? addr1  : addr0;
          wdata_d = winner ? wdata1 : wdata0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // MEM read data arrives the cycle after MREAD, i.e. during WAIT.
        if (!we_q) begin
          if (grant_q) begin
            rdata1_d = mem_rdata;
          end else begin
            rdata0_d = mem_rdata;
          end
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Command bus decoded from the current-state register only, so a write in
  // ISSUE still reaches memory even if reset is sampled in that same cycle.
  assign mem_cmd   = (state_q == ST_ISSUE) ? cmd_for(we_q) : MNONE;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign ack0   = (state_q == ST_DONE) && !grant_q;
  assign ack1   = (state_q == ST_DONE) &&  grant_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign busy   = (state_q != ST_IDLE);
  assign grant  = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a registered-read memory model and
// a transaction-level reference model (shadow memory, last-granted port).
module tb_mem_arbiter;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_READ  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic [1:0]  mem_cmd;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy, grant;

  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;
  logic [15:0] tb_mem [256];

  int          checks = 0;
  int          failures = 0;
  logic [15:0] shadow [256];
  logic [15:0] exp_rd [2];
  bit          model_last;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant(grant)
  );

  // Synchronous-read memory: data valid the cycle after the read command.
  always @(posedge clk) begin
    if (pre_we) tb_mem[pre_addr] <= pre_data;
    else if (mem_cmd == C_WRITE) tb_mem[mem_addr] <= mem_wdata;
    mem_rdata <= tb_mem[mem_addr];
  end

  // Reference arbitration rule: lone requester wins; on contention port 0
  // (fixed) or the port not granted last (round robin).
  function automatic bit model_pick(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return ~model_last;
`else
      return 1'b0;
`endif
    end
    return r1;
  endfunction

  task automatic do_reset();
    reset = 1'b1; req0 = 0; req1 = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_last = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
    shadow[a] = d;
  endtask

  // Drives one or two simultaneous requests from an IDLE cycle and observes
  // the bus; each req drops right after its ack. Returns at posedge+1 in IDLE.
  task automatic drive(input bit r0, input bit r1, input bit w0, input bit w1,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1,
                       output int t0, output int t1,
                       output logic [15:0] rd0, output logic [15:0] rd1,
                       output int n_is0, output int n_is1,
                       output logic [1:0] c_is0, output logic [1:0] c_is1,
                       output logic [7:0] a_is0, output logic [7:0] a_is1,
                       output int extra);
    bit p0, p1, got0, got1;
    int ncmd;
    t0 = -1; t1 = -1; rd0 = '0; rd1 = '0; n_is0 = -1; n_is1 = -1;
    c_is0 = C_NONE; c_is1 = C_NONE; a_is0 = '0; a_is1 = '0; extra = 0; ncmd = 0;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    p0 = r0; p1 = r1;
    for (int n = 1; n <= 24 && (p0 || p1); n++) begin
      @(negedge clk);
      got0 = 0; got1 = 0;
      if (mem_cmd != C_NONE) begin
        if (ncmd == 0) begin n_is0 = n; c_is0 = mem_cmd; a_is0 = mem_addr; end
        else if (ncmd == 1) begin n_is1 = n; c_is1 = mem_cmd; a_is1 = mem_addr; end
        else extra++;
        ncmd++;
      end
      if (ack0) begin
        if (p0) begin t0 = n; rd0 = rdata0; got0 = 1; end else extra++;
      end
      if (ack1) begin
        if (p1) begin t1 = n; rd1 = rdata1; got1 = 1; end else extra++;
      end
      @(posedge clk);
      #1;
      if (got0) begin p0 = 0; req0 = 0; end
      if (got1) begin p1 = 0; req1 = 0; end
    end
    req0 = 0; req1 = 0;
    $display("txn r0=%0b r1=%0b we0=%0b we1=%0b a0=%02h a1=%02h ack0_cyc=%0d ack1_cyc=%0d rd0=%04h rd1=%04h",
             r0, r1, w0, w1, a0, a1, t0, t1, rd0, rd1);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (mem_cmd !== C_NONE) begin failures++; $display("FAIL reset_mem_cmd got=%0h want=0", mem_cmd); end
    checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL reset_mem_addr got=%0h want=0", mem_addr); end
    checks++; if (mem_wdata !== 16'h0) begin failures++; $display("FAIL reset_mem_wdata got=%0h want=0", mem_wdata); end
    checks++; if ({ack0, ack1} !== 2'b00) begin failures++; $display("FAIL reset_acks got=%0b want=00", {ack0, ack1}); end
    checks++; if (rdata0 !== 16'h0 || rdata1 !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%0h/%0h want=0/0", rdata0, rdata1); end
    checks++; if (grant !== 1'b0) begin failures++; $display("FAIL reset_grant got=%0b want=0", grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
  endtask

  task automatic test_single_read();
    int t0, t1, n0, n1, ex; logic [15:0] r0, r1; logic [1:0] c0, c1; logic [7:0] a0, a1;
    preload(8'h05, 16'hABCD);
    drive(1, 0, 0, 0, 8'h05, 8'h00, 16'h0, 16'h0, t0, t1, r0, r1, n0, n1, c0, c1, a0, a1, ex);
    model_last = 0; exp_rd[0] = 16'hABCD;
    checks++; if (n0 !== 2 || c0 !== C_READ || a0 !== 8'h05) begin failures++; $display("FAIL single_read_issue got=cyc%0d cmd%0h addr%0h want=cyc2 cmd1 addr05", n0, c0, a0); end
    checks++; if (t0 !== 4) begin failures++; $display("FAIL single_read_ack_cycle got=%0d want=4", t0); end
    checks++; if (r0 !== 16'hABCD) begin failures++; $display("FAIL single_read_rdata got=%04h want=abcd", r0); end
    checks++; if (t1 !== -1 || ex !== 0) begin failures++; $display("FAIL single_read_no_ack1 got=ack1cyc%0d extra%0d want=none", t1, ex); end
  endtask

  task automatic test_write_readback();
    int t0, t1, n0, n1, ex; logic [15:0] r0, r1; logic [1:0] c0, c1; logic [7:0] a0, a1;
    drive(0, 1, 0, 1, 8'h00, 8'h10, 16'h0, 16'h1234, t0, t1, r0, r1, n0, n1, c0, c1, a0, a1, ex);
    shadow[8'h10] = 16'h1234; model_last = 1;
    checks++; if (n0 !== 2 || c0 !== C_WRITE || a0 !== 8'h10) begin failures++; $display("FAIL wr_issue got=cyc%0d cmd%0h addr%0h want=cyc2 cmd2 addr10", n0, c0, a0); end
    checks++; if (t1 !== 4 || ex !== 0) begin failures++; $display("FAIL wr_ack1 got=cyc%0d extra%0d want=4/0", t1, ex); end
    checks++; if (r1 !== exp_rd[1]) begin failures++; $display("FAIL wr_rdata1_held got=%04h want=%04h", r1, exp_rd[1]); end
    checks++; if (tb_mem[8'h10] !== 16'h1234) begin failures++; $display("FAIL wr_mem got=%04h want=1234", tb_mem[8'h10]); end
    drive(0, 1, 0, 0, 8'h00, 8'h10, 16'h0, 16'h0, t0, t1, r0, r1, n0, n1, c0, c1, a0, a1, ex);
    exp_rd[1] = shadow[8'h10];
    checks++; if (t1 !== 4 || r1 !== exp_rd[1]) begin failures++; $display("FAIL rb_rdata1 got=cyc%0d %04h want=cyc4 %04h", t1, r1, exp_rd[1]); end
    checks++; if (rdata0 !== exp_rd[0]) begin failures++; $display("FAIL rb_rdata0_held got=%04h want=%04h", rdata0, exp_rd[0]); end
  endtask

  task automatic test_contention();
    int t0, t1, n0, n1, ex; logic [15:0] r0, r1; logic [1:0] c0, c1; logic [7:0] a0, a1;
    bit win; int tw, tl;
    do_reset();
    preload(8'h41, 16'h4141);
    preload(8'h42, 16'h4242);
    for (int k = 0; k < 2; k++) begin
      win = model_pick(1, 1);
      model_last = ~win;  // loser is granted after the winner
      exp_rd[0] = shadow[8'h41]; exp_rd[1] = shadow[8'h42];
      drive(1, 1, 0, 0, 8'h41, 8'h42, 16'h0, 16'h0, t0, t1, r0, r1, n0, n1, c0, c1, a0, a1, ex);
      tw = win ? t1 : t0; tl = win ? t0 : t1;
      checks++; if (tw !== 4 || tl !== 8) begin failures++; $display("FAIL contention%0d_order got=win%0d lose%0d want=4/8 winner=%0d", k, tw, tl, win); end
      checks++; if (a0 !== (win ? 8'h42 : 8'h41) || n1 !== 6) begin failures++; $display("FAIL contention%0d_issue got=addr%0h cyc2nd%0d want=winner%0d cyc6", k, a0, n1, win); end
      checks++; if (r0 !== exp_rd[0] || r1 !== exp_rd[1] || ex !== 0) begin failures++; $display("FAIL contention%0d_rdata got=%04h/%04h extra%0d want=%04h/%04h", k, r0, r1, ex, exp_rd[0], exp_rd[1]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] adr [3];
    int issue_n [3]; int ack_n [3]; logic [15:0] rd [3];
    int ni, na, busy_low; bit got;
    adr[0] = 8'h60; adr[1] = 8'h61; adr[2] = 8'h62;
    for (int i = 0; i < 3; i++) preload(adr[i], 16'(32'h600 + i * 7));
    ni = 0; na = 0; busy_low = 0;
    req0 = 1; we0 = 0; addr0 = adr[0]; wdata0 = 16'h0;
    for (int n = 1; n <= 20 && na < 3; n++) begin
      @(negedge clk);
      got = 0;
      if (mem_cmd == C_READ) begin if (ni < 3) issue_n[ni] = n; ni++; end
      if (mem_cmd == C_WRITE) ni += 10;
      if (ni > 0 && !busy) busy_low++;
      if (ack0) begin if (na < 3) begin ack_n[na] = n; rd[na] = rdata0; end na++; got = 1; end
      @(posedge clk);
      #1;
      if (got) begin
        if (na < 3) addr0 = adr[na]; else req0 = 0;
      end
    end
    req0 = 0;
    model_last = 0;
    checks++; if (ni !== 3 || na !== 3) begin failures++; $display("FAIL b2b_counts got=issues%0d acks%0d want=3/3", ni, na); end
    if (ni == 3 && na == 3) begin
      for (int i = 0; i < 3; i++) begin
        exp_rd[0] = shadow[adr[i]];
        $display("txn b2b port0 read a=%02h issue_cyc=%0d ack_cyc=%0d rd=%04h", adr[i], issue_n[i], ack_n[i], rd[i]);
        checks++; if (issue_n[i] !== 2 + 4 * i || ack_n[i] !== 4 + 4 * i) begin failures++; $display("FAIL b2b_timing%0d got=issue%0d ack%0d want=%0d/%0d", i, issue_n[i], ack_n[i], 2 + 4 * i, 4 + 4 * i); end
        checks++; if (rd[i] !== exp_rd[0]) begin failures++; $display("FAIL b2b_rdata%0d got=%04h want=%04h", i, rd[i], exp_rd[0]); end
      end
      checks++; if (busy_low !== 2) begin failures++; $display("FAIL b2b_busy_gap got=%0d want=2", busy_low); end
    end
  endtask

  task automatic test_random();
    int t [2]; int n0, n1, ex; logic [15:0] r [2]; logic [1:0] c0, c1; logic [7:0] a0, a1;
    bit rq [2]; bit w [2]; logic [7:0] a [2]; logic [15:0] d [2];
    int exp_t [2]; logic [1:0] exp_c [2]; logic [7:0] exp_a [2];
    int mode; bit win; int first;
    for (int it = 0; it < 30; it++) begin
      mode = int'($urandom_range(0, 2));
      rq[0] = (mode != 1); rq[1] = (mode != 0);
      for (int p = 0; p < 2; p++) begin
        w[p] = 1'($urandom_range(0, 1));
        a[p] = 8'($urandom_range(0, 15));
        d[p] = 16'($urandom);
      end
      win = model_pick(rq[0], rq[1]);
      exp_t[0] = -1; exp_t[1] = -1;
      for (int k = 0; k < 2; k++) begin
        int p;
        p = (k == 0) ? int'(win) : int'(~win);
        if (k == 1 && !(rq[0] && rq[1])) break;
        model_last = p[0];
        exp_t[p] = 4 + 4 * k;
        exp_c[k] = w[p] ? C_WRITE : C_READ;
        exp_a[k] = a[p];
        if (w[p]) shadow[a[p]] = d[p];
        else exp_rd[p] = shadow[a[p]];
      end
      drive(rq[0], rq[1], w[0], w[1], a[0], a[1], d[0], d[1], t[0], t[1], r[0], r[1],
            n0, n1, c0, c1, a0, a1, ex);
      first = 0;
      checks++; if (t[0] !== exp_t[0] || t[1] !== exp_t[1] || ex !== 0) begin failures++; $display("FAIL rand%0d_ack got=%0d/%0d extra%0d want=%0d/%0d", it, t[0], t[1], ex, exp_t[0], exp_t[1]); end
      checks++; if (n0 !== 2 || c0 !== exp_c[first] || a0 !== exp_a[first]) begin failures++; $display("FAIL rand%0d_issue got=cyc%0d cmd%0h addr%0h want=cyc2 cmd%0h addr%0h", it, n0, c0, a0, exp_c[0], exp_a[0]); end
      if (rq[0] && rq[1]) begin
        checks++; if (n1 !== 6 || c1 !== exp_c[1] || a1 !== exp_a[1]) begin failures++; $display("FAIL rand%0d_issue2 got=cyc%0d cmd%0h addr%0h want=cyc6 cmd%0h addr%0h", it, n1, c1, a1, exp_c[1], exp_a[1]); end
      end
      checks++; if (rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1]) begin failures++; $display("FAIL rand%0d_rdata got=%04h/%04h want=%04h/%04h", it, rdata0, rdata1, exp_rd[0], exp_rd[1]); end
      checks++; if (grant !== model_last || busy !== 1'b0) begin failures++; $display("FAIL rand%0d_grant got=%0b busy%0b want=%0b busy0", it, grant, busy, model_last); end
    end
  endtask

  task automatic test_reset_mid_read();
    int t0, t1, n0, n1, ex, acks; logic [15:0] r0, r1; logic [1:0] c0, c1; logic [7:0] a0, a1;
    preload(8'h33, 16'h5A5A);
    preload(8'h34, 16'hC3C3);
    drive(1, 0, 0, 0, 8'h33, 8'h00, 16'h0, 16'h0, t0, t1, r0, r1, n0, n1, c0, c1, a0, a1, ex);
    checks++; if (r0 !== 16'h5A5A) begin failures++; $display("FAIL rst_read_pre got=%04h want=5a5a", r0); end
    req0 = 1; we0 = 0; addr0 = 8'h34;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_cmd !== C_READ) begin failures++; $display("FAIL rst_read_issue got=%0h want=1", mem_cmd); end
    @(negedge clk);
    reset = 1; req0 = 0;
    @(posedge clk);
    #1 reset = 0;
    model_last = 0; exp_rd[0] = '0; exp_rd[1] = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || mem_cmd !== C_NONE) begin failures++; $display("FAIL rst_read_idle got=busy%0b cmd%0h want=0/0", busy, mem_cmd); end
    checks++; if (rdata0 !== 16'h0) begin failures++; $display("FAIL rst_read_rdata0 got=%04h want=0", rdata0); end
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (ack0 || ack1) acks++;
      @(negedge clk);
    end
    checks++; if (acks !== 0) begin failures++; $display("FAIL rst_read_no_ack got=%0d want=0", acks); end
    $display("txn reset_mid_read a=34 acks_after=%0d", acks);
  endtask

  task automatic test_reset_write_issue();
    int acks;
    @(posedge clk);
    #1;
    preload(8'h20, 16'h0000);
    req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 16'hBEEF;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_cmd !== C_WRITE) begin failures++; $display("FAIL rst_wr_issue got=%0h want=2", mem_cmd); end
    reset = 1; req0 = 0; we0 = 0;
    @(posedge clk);
    #1 reset = 0;
    model_last = 0; exp_rd[0] = '0; exp_rd[1] = '0; shadow[8'h20] = 16'hBEEF;
    @(negedge clk);
    checks++; if (tb_mem[8'h20] !== 16'hBEEF) begin failures++; $display("FAIL rst_wr_mem got=%04h want=beef", tb_mem[8'h20]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_wr_idle got=%0b want=0", busy); end
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (ack0 || ack1) acks++;
      @(negedge clk);
    end
    checks++; if (acks !== 0) begin failures++; $display("FAIL rst_wr_no_ack got=%0d want=0", acks); end
    $display("txn reset_write_issue a=20 mem=%04h acks_after=%0d", tb_mem[8'h20], acks);
  endtask

  initial begin
    reset = 1; req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    pre_we = 0; pre_addr = 0; pre_data = 0;
    test_reset();
    for (int i = 0; i < 256; i++) preload(8'(i), 16'($urandom));
    test_single_read();
    test_write_readback();
    test_contention();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    test_reset_write_issue();
    @(posedge clk);
    #1;
    // The arbiter must still work after a mid-operation reset.
    test_single_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
